// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared types and helpers for the iterative signed divider.
//   state_e      - divider FSM states
//   cnt_width()  - width of the iteration counter for an N-step divide
//   sat_*_mag()  - saturation magnitudes derived from the operand width
package seq_div_pkg;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  // Widest operand the saturation helpers can describe.
  localparam int unsigned MaxWidth = 128;

  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Largest positive quotient magnitude: 2^(width-1)-1.
  function automatic logic [MaxWidth-1:0] sat_pos_mag(int unsigned width);
    return (MaxWidth'(1) << (width - 1)) - MaxWidth'(1);
  endfunction

  // Largest negative quotient magnitude: 2^(width-1).
  function automatic logic [MaxWidth-1:0] sat_neg_mag(int unsigned width);
    return MaxWidth'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/sdiv_abs.sv
// sdiv_abs: combinational two's-complement conditional negate.
//   din  - operand
//   neg  - 1: dout = -din, 0: dout = din
//   dout - result; with neg = din[MSB] it is |din| read as unsigned, so the
//          most negative value maps exactly onto 2^(WIDTH-1).
module sdiv_abs #(
  parameter int unsigned WIDTH = 56
) (
  input  logic [WIDTH-1:0] din,
  input  logic             neg,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/seq_signed_div.sv
// seq_signed_div: handshaked signed fixed-point divider, one restoring step per
// cycle. The dividend is scaled by 2^FRAC_BITS before dividing.
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - operand handshake (ready only while idle)
//   din1, din2          - signed dividend, signed divisor
//   out_valid/out_ready - result handshake; outputs held while stalled
//   quot, rem           - signed quotient, remainder of the scaled dividend
//   div_zero, ovf       - divisor was zero / quotient saturated
// Build option: define SEQ_SIGNED_DIV_ROUND_EN to round the quotient half away
// from zero instead of truncating toward zero.
module seq_signed_div
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH     = 56,
  parameter int unsigned FRAC_BITS = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero,
  output logic             ovf
);

  localparam int unsigned N    = WIDTH + FRAC_BITS;
  localparam int unsigned CntW = cnt_width(N);

  localparam logic [WIDTH-1:0] SatPos = WIDTH'(sat_pos_mag(WIDTH));
  localparam logic [WIDTH-1:0] SatNeg = WIDTH'(sat_neg_mag(WIDTH));
  localparam logic [N:0]       LimPos = (N+1)'(sat_pos_mag(WIDTH));
  localparam logic [N:0]       LimNeg = (N+1)'(sat_neg_mag(WIDTH));

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  // Scaled dividend shifts out of the top while quotient bits shift in below.
  logic [N-1:0]      quo_q;
  logic [WIDTH-1:0]  prem_q;
  logic [WIDTH-1:0]  dvs_q;
  logic              sign_q_q;
  logic              sign_r_q;

  logic [WIDTH-1:0]  mag1, mag2;
  logic [WIDTH:0]    shifted, trial;
  logic [N:0]        qmag;
  logic [WIDTH-1:0]  rmag, quot_s, rem_s;
  logic              round_up, rem_neg, ovf_c;

  sdiv_abs #(.WIDTH(WIDTH)) u_abs_dividend (
    .din  (din1),
    .neg  (din1[WIDTH-1]),
    .dout (mag1)
  );

  sdiv_abs #(.WIDTH(WIDTH)) u_abs_divisor (
    .din  (din2),
    .neg  (din2[WIDTH-1]),
    .dout (mag2)
  );

  sdiv_abs #(.WIDTH(WIDTH)) u_sign_quot (
    .din  (qmag[WIDTH-1:0]),
    .neg  (sign_q_q),
    .dout (quot_s)
  );

  sdiv_abs #(.WIDTH(WIDTH)) u_sign_rem (
    .din  (rmag),
    .neg  (rem_neg),
    .dout (rem_s)
  );

  always_comb begin
    shifted = {prem_q, quo_q[N-1]};
    trial   = shifted - {1'b0, dvs_q};
`ifdef SEQ_SIGNED_DIV_ROUND_EN
    round_up = ({prem_q, 1'b0} >= {1'b0, dvs_q});
`else
    round_up = 1'b0;
`endif
    qmag    = {1'b0, quo_q} + {{N{1'b0}}, round_up};
    // Rounding up leaves din1_scaled - quot*din2 with the opposite sign of din1.
    rmag    = round_up ? (dvs_q - prem_q) : prem_q;
    rem_neg = sign_r_q ^ round_up;
    ovf_c   = sign_q_q ? (qmag > LimNeg) : (qmag > LimPos);
  end

  assign in_ready = (state_q == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      quo_q     <= '0;
      prem_q    <= '0;
      dvs_q     <= '0;
      sign_q_q  <= 1'b0;
      sign_r_q  <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            sign_q_q <= din1[WIDTH-1] ^ din2[WIDTH-1];
            sign_r_q <= din1[WIDTH-1];
            quo_q    <= N'(mag1) << FRAC_BITS;
            dvs_q    <= mag2;
            prem_q   <= '0;
            cnt_q    <= CntW'(N - 1);
            state_q  <= (din2 == '0) ? StFix : StCalc;
          end
        end
        StCalc: begin
          // Keep the trial difference only when it did not go negative.
          quo_q  <= {quo_q[N-2:0], ~trial[WIDTH]};
          prem_q <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          cnt_q  <= cnt_q - CntW'(1);
          if (cnt_q == '0) state_q <= StFix;
        end
        StFix: begin
          if (dvs_q == '0) begin
            div_zero <= 1'b1;
            ovf      <= 1'b0;
            rem      <= '0;
            quot     <= (quo_q == '0) ? '0 : (sign_r_q ? SatNeg : SatPos);
          end else if (ovf_c) begin
            div_zero <= 1'b0;
            ovf      <= 1'b1;
            rem      <= '0;
            quot     <= sign_q_q ? SatNeg : SatPos;
          end else begin
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            rem      <= rem_s;
            quot     <= quot_s;
          end
          state_q <= StDone;
        end
        StDone: begin
          // First DONE cycle raises out_valid; results are already stable.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
